// File: rtl/pkt_conf_pkg.sv
// Shared definitions for the configuration-packet responder: beat layout,
// tag encodings, field positions, FSM states and small field helpers.
package pkt_conf_pkg;

   localparam int BEAT_W  = 134;
   localparam int TAG_HI  = 133;
   localparam int TAG_LO  = 132;
   localparam int CODE_HI = 131;
   localparam int CODE_LO = 128;

   localparam logic [1:0] TAG_HEAD      = 2'b01;
   localparam logic [1:0] TAG_TAIL      = 2'b10;
   localparam logic [1:0] TAG_HEAD_TAIL = 2'b11;
   localparam logic [3:0] CODE_FULL     = 4'hf;

   localparam int ETYPE_HI = 31;
   localparam int ETYPE_LO = 16;
   localparam int SEL_BIT  = 16;
   localparam int ADDR_HI  = 47;
   localparam int ADDR_LO  = 16;
   localparam int DATA_HI  = 79;
   localparam int DATA_LO  = 48;
   localparam int DA_HI    = 127;
   localparam int DA_LO    = 80;
   localparam int SA_HI    = 79;
   localparam int SA_LO    = 32;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR_SEL,
      ST_RD_SEL,
      ST_WR_PROG,
      ST_RD_PROG,
      ST_BYPASS
   } state_e;

   // The four configuration ethertypes are consecutive starting at base.
   function automatic state_e decode_etype(input logic [15:0] etype,
                                           input logic [15:0] base);
      state_e st;
      st = ST_BYPASS;
      if (etype == base)
         st = ST_WR_SEL;
      else if (etype == base + 16'd1)
         st = ST_RD_SEL;
      else if (etype == base + 16'd2)
         st = ST_WR_PROG;
      else if (etype == base + 16'd3)
         st = ST_RD_PROG;
      return st;
   endfunction

   function automatic logic [BEAT_W-1:0] swap_mac(input logic [BEAT_W-1:0] beat);
      logic [BEAT_W-1:0] r;
      r = beat;
      r[DA_HI:DA_LO] = beat[SA_HI:SA_LO];
      r[SA_HI:SA_LO] = beat[DA_HI:DA_LO];
      return r;
   endfunction

endpackage

// File: rtl/pkt_resp_pipe.sv
// Two-stage response delay line; program read data is merged into the
// outgoing beat at the second stage, when the memory presents it.
module pkt_resp_pipe
   import pkt_conf_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   input  logic [BEAT_W-1:0] in_beat,
   input  logic              in_sub,
   input  logic              in_hit,
   input  logic [31:0]       rdata,
   output logic              out_valid,
   output logic [BEAT_W-1:0] out_beat
);

   logic              s1_valid;
   logic [BEAT_W-1:0] s1_beat;
   logic              s1_sub;
   logic              s1_hit;
   logic              s2_valid;
   logic [BEAT_W-1:0] s2_beat;
   logic              s2_sub;
   logic              s2_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_beat  <= '0;
         s1_sub   <= 1'b0;
         s1_hit   <= 1'b0;
         s2_valid <= 1'b0;
         s2_beat  <= '0;
         s2_sub   <= 1'b0;
         s2_hit   <= 1'b0;
      end else begin
         s1_valid <= in_valid;
         s1_beat  <= in_valid ? in_beat : '0;
         s1_sub   <= in_valid & in_sub;
         s1_hit   <= in_valid & in_hit;
         s2_valid <= s1_valid;
         s2_beat  <= s1_beat;
         s2_sub   <= s1_sub;
         s2_hit   <= s1_hit;
      end
   end

   // Out-of-range reads never touched memory, so they return zero.
   always_comb begin
      out_valid = s2_valid;
      out_beat  = s2_beat;
      if (s2_sub)
         out_beat[DATA_HI:DATA_LO] = s2_hit ? rdata : 32'd0;
   end

endmodule

// File: rtl/pkt_conf_responder.sv
// Packet-stream configuration responder: bypasses ordinary traffic, and
// handles select-register and program-memory write/read packets.
module pkt_conf_responder
   import pkt_conf_pkg::*;
#(
   parameter int          PROG_AW         = 14,
   parameter logic [15:0] CONF_ETYPE_BASE = 16'h9001
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               data_in_valid,
   input  logic [BEAT_W-1:0]  data_in,
   output logic               bypass_out_valid,
   output logic [BEAT_W-1:0]  bypass_out,
   output logic               resp_out_valid,
   output logic [BEAT_W-1:0]  resp_out,
   output logic               conf_sel,
   output logic               prog_wren,
   output logic               prog_rden,
   output logic [PROG_AW-1:0] prog_addr,
   output logic [31:0]        prog_wdata,
   input  logic [31:0]        prog_rdata
);

   localparam logic [32:0] ADDR_LIMIT = 33'd1 << PROG_AW;

   state_e            state;
   state_e            state_next;
   state_e            head_state;
   state_e            eff_state;
   logic              first_pending;
   logic [1:0]        tag;
   logic [3:0]        code;
   logic              is_head;
   logic              is_tail;
   logic [31:0]       addr_field;
   logic              addr_ok;
   logic              bypass_fire;
   logic              wr_sel_fire;
   logic              wr_prog_fire;
   logic              rd_prog_fire;
   logic              resp_push;
   logic              resp_sub;
   logic [BEAT_W-1:0] resp_beat;

   assign tag        = data_in[TAG_HI:TAG_LO];
   assign code       = data_in[CODE_HI:CODE_LO];
   assign is_head    = (tag == TAG_HEAD) || (tag == TAG_HEAD_TAIL);
   assign is_tail    = (tag == TAG_TAIL) || (tag == TAG_HEAD_TAIL);
   assign addr_field = data_in[ADDR_HI:ADDR_LO];
   assign addr_ok    = {1'b0, addr_field} < ADDR_LIMIT;

   // A head beat is classified on its own ethertype, even mid-packet, so an
   // interrupted packet is simply abandoned.
   always_comb begin
      head_state   = decode_etype(data_in[ETYPE_HI:ETYPE_LO], CONF_ETYPE_BASE);
      eff_state    = is_head ? head_state : state;
      bypass_fire  = data_in_valid && (eff_state == ST_BYPASS);
      wr_sel_fire  = data_in_valid && !is_head && (state == ST_WR_SEL) && first_pending;
      wr_prog_fire = data_in_valid && !is_head && (state == ST_WR_PROG) &&
                     (code == CODE_FULL) && conf_sel && addr_ok;
      rd_prog_fire = data_in_valid && !is_head && (state == ST_RD_PROG) && addr_ok;
      resp_push    = data_in_valid &&
                     ((eff_state == ST_RD_SEL) || (eff_state == ST_RD_PROG));
      resp_sub     = !is_head && (state == ST_RD_PROG);
      resp_beat    = data_in;
      if (is_head)
         resp_beat = swap_mac(data_in);
      else if ((state == ST_RD_SEL) && first_pending)
         resp_beat[SEL_BIT] = conf_sel;
   end

   always_comb begin
      state_next = state;
      if (data_in_valid) begin
         if (is_head)
            state_next = is_tail ? ST_IDLE : head_state;
         else if (is_tail)
            state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Strobes and bypass data are registered one cycle behind the input beat.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bypass_out_valid <= 1'b0;
         bypass_out       <= '0;
         prog_wren        <= 1'b0;
         prog_rden        <= 1'b0;
         prog_addr        <= '0;
         prog_wdata       <= '0;
         conf_sel         <= 1'b0;
         first_pending    <= 1'b0;
      end else begin
         bypass_out_valid <= bypass_fire;
         bypass_out       <= bypass_fire ? data_in : '0;
         prog_wren        <= wr_prog_fire;
         prog_rden        <= rd_prog_fire;
         prog_addr        <= (wr_prog_fire || rd_prog_fire) ? addr_field[PROG_AW-1:0] : '0;
         prog_wdata       <= wr_prog_fire ? data_in[DATA_HI:DATA_LO] : 32'd0;
         if (wr_sel_fire)
            conf_sel <= data_in[SEL_BIT];
         if (data_in_valid) begin
            if (is_head)
               first_pending <= 1'b1;
            else if (state != ST_IDLE)
               first_pending <= 1'b0;
         end
      end
   end

   pkt_resp_pipe u_resp_pipe (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (resp_push),
      .in_beat   (resp_beat),
      .in_sub    (resp_sub),
      .in_hit    (addr_ok),
      .rdata     (prog_rdata),
      .out_valid (resp_out_valid),
      .out_beat  (resp_out)
   );

endmodule

// File: tb/tb_pkt_conf_responder.sv
// Randomized scoreboard bench for pkt_conf_responder with a packet-level
// reference model and a simple program-memory responder.
module tb_pkt_conf_responder;

   localparam int AW    = 14;
   localparam int DEPTH = 1 << AW;
   localparam int K_NONE = 0, K_WSEL = 1, K_RSEL = 2, K_WPROG = 3, K_RPROG = 4, K_BYP = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          data_in_valid = 1'b0;
   logic [133:0]  data_in = '0;
   logic [31:0]   prog_rdata = '0;
   logic          bypass_out_valid;
   logic [133:0]  bypass_out;
   logic          resp_out_valid;
   logic [133:0]  resp_out;
   logic          conf_sel;
   logic          prog_wren;
   logic          prog_rden;
   logic [AW-1:0] prog_addr;
   logic [31:0]   prog_wdata;

   typedef struct {
      int           due;
      logic [133:0] beat;
   } beat_exp_t;

   typedef struct {
      int          due;
      logic [AW-1:0] addr;
      logic [31:0] wdata;
      logic [31:0] old;
   } wr_exp_t;

   beat_exp_t   byp_q[$];
   beat_exp_t   resp_q[$];
   wr_exp_t     wr_q[$];
   beat_exp_t   mb;
   wr_exp_t     mw;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [31:0] env_mem [DEPTH];
   logic [31:0] ref_mem [DEPTH];
   int          ref_kind = K_NONE;
   bit          ref_first = 1'b0;
   bit          ref_conf = 1'b0;

   pkt_conf_responder #(
      .PROG_AW         (AW),
      .CONF_ETYPE_BASE (16'h9001)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .data_in_valid    (data_in_valid),
      .data_in          (data_in),
      .bypass_out_valid (bypass_out_valid),
      .bypass_out       (bypass_out),
      .resp_out_valid   (resp_out_valid),
      .resp_out         (resp_out),
      .conf_sel         (conf_sel),
      .prog_wren        (prog_wren),
      .prog_rden        (prog_rden),
      .prog_addr        (prog_addr),
      .prog_wdata       (prog_wdata),
      .prog_rdata       (prog_rdata)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Program memory: read data appears the cycle after prog_rden, garbage otherwise.
   always @(posedge clk) begin
      if (prog_wren)
         env_mem[prog_addr] <= prog_wdata;
      prog_rdata <= prog_rden ? env_mem[prog_addr] : $urandom;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         while (byp_q.size() > 0 && byp_q[0].due < cyc) begin
            checks++; errors++;
            $display("[TB] FAIL bypass_missing: beat due cycle %0d absent, got nothing by cycle %0d (want %h)",
                     byp_q[0].due, cyc, byp_q[0].beat);
            void'(byp_q.pop_front());
         end
         if (bypass_out_valid) begin
            checks++;
            if (byp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL bypass_unexpected: got %h at cycle %0d, want no beat", bypass_out, cyc);
            end else begin
               mb = byp_q.pop_front();
               if (mb.due != cyc || mb.beat !== bypass_out) begin
                  errors++;
                  $display("[TB] FAIL bypass_beat: got %h at cycle %0d, want %h at cycle %0d",
                           bypass_out, cyc, mb.beat, mb.due);
               end
            end
         end
         while (resp_q.size() > 0 && resp_q[0].due < cyc) begin
            checks++; errors++;
            $display("[TB] FAIL resp_missing: beat due cycle %0d absent, got nothing by cycle %0d (want %h)",
                     resp_q[0].due, cyc, resp_q[0].beat);
            void'(resp_q.pop_front());
         end
         if (resp_out_valid) begin
            checks++;
            if (resp_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL resp_unexpected: got %h at cycle %0d, want no beat", resp_out, cyc);
            end else begin
               mb = resp_q.pop_front();
               if (mb.due != cyc || mb.beat !== resp_out) begin
                  errors++;
                  $display("[TB] FAIL resp_beat: got %h at cycle %0d, want %h at cycle %0d",
                           resp_out, cyc, mb.beat, mb.due);
               end
            end
         end
         while (wr_q.size() > 0 && wr_q[0].due < cyc) begin
            checks++; errors++;
            $display("[TB] FAIL write_missing: write addr %h data %h due cycle %0d absent at cycle %0d",
                     wr_q[0].addr, wr_q[0].wdata, wr_q[0].due, cyc);
            void'(wr_q.pop_front());
         end
         if (prog_wren) begin
            checks++;
            if (wr_q.size() == 0) begin
               errors++;
               $display("[TB] FAIL write_unexpected: got addr %h data %h at cycle %0d, want no write",
                        prog_addr, prog_wdata, cyc);
            end else begin
               mw = wr_q.pop_front();
               if (mw.due != cyc || mw.addr !== prog_addr || mw.wdata !== prog_wdata) begin
                  errors++;
                  $display("[TB] FAIL write: got addr %h data %h cycle %0d, want addr %h data %h cycle %0d",
                           prog_addr, prog_wdata, cyc, mw.addr, mw.wdata, mw.due);
               end
            end
         end
      end
   end

   function automatic int decode(input logic [15:0] etype);
      case (etype)
         16'h9001: return K_WSEL;
         16'h9002: return K_RSEL;
         16'h9003: return K_WPROG;
         16'h9004: return K_RPROG;
         default:  return K_BYP;
      endcase
   endfunction

   // Reference model: interprets each beat at packet level and queues the
   // externally visible effects it must cause.
   task automatic model_beat(input logic [1:0] tag, input logic [3:0] code, input logic [127:0] pl);
      bit           head;
      bit           tail;
      logic [133:0] beat;
      logic [133:0] r;
      logic [31:0]  a;
      bit           in_mem;
      beat_exp_t    e;
      wr_exp_t      w;
      head   = (tag == 2'b01) || (tag == 2'b11);
      tail   = (tag == 2'b10) || (tag == 2'b11);
      beat   = {tag, code, pl};
      a      = pl[47:16];
      in_mem = a < 32'(DEPTH);
      if (head) begin
         ref_kind  = decode(pl[31:16]);
         ref_first = 1'b1;
      end
      r = beat;
      if (head) begin
         r[127:80] = beat[79:32];
         r[79:32]  = beat[127:80];
      end
      case (ref_kind)
         K_BYP: begin
            e.due = cyc + 1; e.beat = beat;
            byp_q.push_back(e);
         end
         K_WSEL: if (!head && ref_first) ref_conf = pl[16];
         K_WPROG: if (!head && code == 4'hf && ref_conf && in_mem) begin
            w.due = cyc + 1; w.addr = a[AW-1:0]; w.wdata = pl[79:48];
            w.old = ref_mem[w.addr];
            ref_mem[w.addr] = w.wdata;
            wr_q.push_back(w);
         end
         K_RSEL: begin
            if (!head && ref_first) r[16] = ref_conf;
            e.due = cyc + 2; e.beat = r;
            resp_q.push_back(e);
         end
         K_RPROG: begin
            if (!head) r[79:48] = in_mem ? ref_mem[a[AW-1:0]] : 32'd0;
            e.due = cyc + 2; e.beat = r;
            resp_q.push_back(e);
         end
         default: ;
      endcase
      if (!head && ref_kind != K_NONE) ref_first = 1'b0;
      if (tail) ref_kind = K_NONE;
   endtask

   task automatic apply_stimulus(input logic [1:0] tag, input logic [3:0] code, input logic [127:0] pl);
      @(posedge clk); #1;
      data_in_valid = 1'b1;
      data_in = {tag, code, pl};
      model_beat(tag, code, pl);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         data_in_valid = 1'b0;
         data_in = {2'($urandom), 4'($urandom), $urandom, $urandom, $urandom, $urandom};
      end
   endtask

   task automatic check_output(input string name);
      logic [340:0] v;
      v = {bypass_out_valid, bypass_out, resp_out_valid, resp_out, conf_sel,
           prog_wren, prog_rden, prog_addr, prog_wdata};
      checks++;
      if (v !== '0) begin
         errors++;
         $display("[TB] FAIL %s: outputs %h, want all zero", name, v);
      end
   endtask

   task automatic check_conf(input string name);
      idle(2);
      checks++;
      if (conf_sel !== ref_conf) begin
         errors++;
         $display("[TB] FAIL %s: conf_sel %b, want %b", name, conf_sel, ref_conf);
      end
   endtask

   // Pending writes are rolled back in the model since reset must cancel them.
   task automatic apply_reset();
      @(posedge clk); #2;
      rst_n = 1'b0;
      data_in_valid = 1'b0;
      for (int i = wr_q.size() - 1; i >= 0; i--)
         ref_mem[wr_q[i].addr] = wr_q[i].old;
      wr_q.delete();
      byp_q.delete();
      resp_q.delete();
      ref_kind = K_NONE;
      ref_first = 1'b0;
      ref_conf = 1'b0;
      #1 check_output("reset_outputs");
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
   endtask

   function automatic logic [3:0] rand_code();
      if ($urandom_range(0, 6) == 0) return 4'($urandom_range(0, 14));
      return 4'hf;
   endfunction

   function automatic logic [127:0] rand_body();
      logic [127:0] pl;
      int r;
      pl = {$urandom, $urandom, $urandom, $urandom};
      r = $urandom_range(0, 19);
      if (r < 12)      pl[47:16] = 32'($urandom_range(0, 15));
      else if (r < 16) pl[47:16] = 32'($urandom_range(0, DEPTH - 1));
      else if (r == 16) pl[47:16] = $urandom | 32'h0000_4000;
      else if (r == 17) pl[47:16] = $urandom | 32'h8000_0000;
      else if (r == 18) pl[47:16] = 32'h0000_3fff;
      else             pl[47:16] = 32'h0000_4000;
      return pl;
   endfunction

   task automatic send_packet(input logic [15:0] etype, input int nbeats, input bit abort);
      logic [127:0] pl;
      pl = {$urandom, $urandom, $urandom, $urandom};
      pl[31:16] = etype;
      apply_stimulus((nbeats == 1 && !abort) ? 2'b11 : 2'b01, rand_code(), pl);
      for (int i = 1; i < nbeats; i++)
         apply_stimulus((i == nbeats - 1 && !abort) ? 2'b10 : 2'b00, rand_code(), rand_body());
   endtask

   function automatic logic [127:0] head_pl(input logic [15:0] etype);
      logic [127:0] pl;
      pl = {$urandom, $urandom, $urandom, $urandom};
      pl[31:16] = etype;
      return pl;
   endfunction

   function automatic logic [127:0] prog_pl(input logic [31:0] instr, input logic [31:0] addr);
      logic [127:0] pl;
      pl = {$urandom, $urandom, $urandom, $urandom};
      pl[79:48] = instr;
      pl[47:16] = addr;
      return pl;
   endfunction

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, want finished", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [31:0] v;
      logic [127:0] pl;
      logic [15:0] et;
      int pick;
      for (int i = 0; i < DEPTH; i++) begin
         v = $urandom;
         env_mem[i] = v;
         ref_mem[i] = v;
      end
      env_mem[1] = 32'h0440_0593;
      ref_mem[1] = 32'h0440_0593;

      #1 rst_n = 1'b0;
      #3 check_output("reset_outputs_initial");
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      // Orphan body and tail before any head must be dropped.
      apply_stimulus(2'b00, 4'hf, rand_body());
      apply_stimulus(2'b10, 4'hf, rand_body());
      idle(1);

      // Select write sets conf_sel from the first body beat only.
      apply_stimulus(2'b01, 4'hf, head_pl(16'h9001));
      apply_stimulus(2'b00, 4'hf, 128'h1_0000);
      apply_stimulus(2'b00, 4'hf, 128'h0);
      apply_stimulus(2'b10, 4'hf, 128'h0);
      check_conf("conf_sel_after_wr_sel");

      apply_stimulus(2'b01, 4'hf, head_pl(16'h9003));
      apply_stimulus(2'b00, 4'hf, prog_pl(32'h1000_0537, 32'd0));
      apply_stimulus(2'b10, 4'h3, prog_pl(32'hdead_beef, 32'd2));
      idle(1);

      apply_stimulus(2'b01, 4'hf, head_pl(16'h9001));
      apply_stimulus(2'b10, 4'hf, 128'h0);
      check_conf("conf_sel_cleared");
      apply_stimulus(2'b01, 4'hf, head_pl(16'h9003));
      apply_stimulus(2'b00, 4'hf, prog_pl(32'h1000_0537, 32'd0));
      apply_stimulus(2'b10, 4'hf, prog_pl(32'h1234_5678, 32'd3));
      idle(1);

      apply_stimulus(2'b01, 4'hf, head_pl(16'h9004));
      apply_stimulus(2'b00, 4'hf, prog_pl($urandom, 32'd1));
      apply_stimulus(2'b10, 4'hf, prog_pl($urandom, 32'd0));
      apply_stimulus(2'b01, 4'hf, head_pl(16'h9004));
      apply_stimulus(2'b10, 4'hf, prog_pl($urandom, 32'h0000_4000));
      idle(2);

      send_packet(16'h0806, 4, 1'b0);
      idle(1);

      apply_stimulus(2'b01, 4'hf, head_pl(16'h9001));
      apply_stimulus(2'b10, 4'hf, 128'h1_0000);
      apply_stimulus(2'b01, 4'hf, head_pl(16'h9003));
      apply_stimulus(2'b01, 4'hf, head_pl(16'h0806));
      apply_stimulus(2'b00, 4'hf, prog_pl(32'h5555_aaaa, 32'd4));
      apply_stimulus(2'b10, 4'hf, prog_pl(32'h5555_aaaa, 32'd5));
      apply_stimulus(2'b01, 4'hf, head_pl(16'h9002));
      apply_stimulus(2'b00, 4'hf, 128'h0);
      apply_stimulus(2'b10, 4'hf, 128'h0);
      check_conf("conf_sel_after_abort");

      // Reset lands on the cycle the body write strobe would appear.
      apply_stimulus(2'b01, 4'hf, head_pl(16'h9003));
      apply_stimulus(2'b00, 4'hf, prog_pl(32'hcafe_f00d, 32'd6));
      apply_reset();
      apply_stimulus(2'b00, 4'hf, prog_pl(32'h0bad_0bad, 32'd7));
      pl = 128'h1_0000;
      apply_stimulus(2'b01, 4'hf, head_pl(16'h9002));
      apply_stimulus(2'b00, 4'hf, pl);
      apply_stimulus(2'b10, 4'hf, pl);
      check_conf("conf_sel_after_reset");

      for (int p = 0; p < 260; p++) begin
         pick = $urandom_range(0, 9);
         case (pick)
            0, 1: et = 16'h9001;
            2:    et = 16'h9002;
            3, 4: et = 16'h9003;
            5, 6: et = 16'h9004;
            7:    et = 16'h0806;
            8:    et = 16'h0800;
            default: et = 16'($urandom);
         endcase
         if ($urandom_range(0, 14) == 0)
            apply_stimulus(2'b00, rand_code(), rand_body());
         send_packet(et, $urandom_range(1, 5), $urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0)
            idle($urandom_range(1, 3));
         if (p % 25 == 24)
            check_conf("conf_sel_random");
         if (p == 130)
            apply_reset();
      end
      idle(6);

      checks++;
      if (byp_q.size() != 0 || resp_q.size() != 0 || wr_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL drain: pending bypass %0d resp %0d write %0d, want 0 0 0",
                  byp_q.size(), resp_q.size(), wr_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pkt_conf_responder.md
PKT_CONF_RESPONDER -- requirements
Module: pkt_conf_responder

Interface
REQ-001 Parameter PROG_AW, default 14, program-memory word-address width (16K words = 64 KB).
REQ-002 Parameter CONF_ETYPE_BASE, default 16'h9001, first of four configuration ethertypes (9001 wr_sel, 9002 rd_sel, 9003 wr_prog, 9004 rd_prog).
REQ-003 clk  input  1  single clock; all logic on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 data_in_valid  input  1  beat valid.
REQ-006 data_in  input  134  [133:132] tag (01 head, 00 body, 10 tail, 11 head+tail), [131:128] valid-byte code (f = full), [127:0] payload.
REQ-007 bypass_out_valid / bypass_out  output  1 / 134  non-configuration packets.
REQ-008 resp_out_valid / resp_out  output  1 / 134  read-response packets.
REQ-009 conf_sel  output  1  configuration-mode register (1 = CPU held, program writable).
REQ-010 prog_wren, prog_rden  output  1 each  program-memory strobes.
REQ-011 prog_addr  output  PROG_AW  word address.
REQ-012 prog_wdata  input-side write data: output  32.
REQ-013 prog_rdata  input  32  read data, valid exactly one cycle after prog_rden.

Function
REQ-014 Head beat: ethertype = data_in[31:16]; match against the four codes selects WR_SEL, RD_SEL, WR_PROG or RD_PROG state; otherwise BYPASS.
REQ-015 FSM states IDLE, WR_SEL, RD_SEL, WR_PROG, RD_PROG, BYPASS; tail beat (tag 10) returns to IDLE on the next cycle; head-only beat (tag 11) returns to IDLE immediately after.
REQ-016 Head beat received in any non-IDLE state aborts the current packet without further side effects and is decoded as a new packet.
REQ-017 Body beats in IDLE (no preceding head) are discarded.
REQ-018 BYPASS: every beat of the packet, head included, appears on bypass_out exactly 1 cycle later, unmodified.
REQ-019 WR_SEL: first non-head beat loads conf_sel <= data_in[16]; later beats ignored; nothing emitted.
REQ-020 WR_PROG: each non-head beat (tail included) with code f and conf_sel = 1 issues prog_wren, prog_addr = data_in[47:16] truncated, prog_wdata = data_in[79:48], same cycle +1 (registered).
REQ-021 WR_PROG writes are suppressed when conf_sel = 0 or data_in[47:16] >= 2^PROG_AW.
REQ-022 RD_PROG: each non-head beat issues prog_rden with the same address field, regardless of conf_sel; out-of-range addresses issue no read and return 0.
REQ-023 Response stream = request stream delayed exactly 2 cycles, same tags and byte codes; head beat has bytes [127:80] and [79:32] (DA/SA) swapped, ethertype and [15:0] unchanged.
REQ-024 RD_PROG response body beat: [79:48] replaced by prog_rdata (or 0), all other bits copied.
REQ-025 RD_SEL response: first body beat has bit 16 replaced by conf_sel; other body beats copied.
REQ-026 WR_SEL and WR_PROG packets emit nothing on either output.
REQ-027 Back-to-back packets (head immediately after tail) processed with no bubble.

Reset
REQ-028 rst_n low: all outputs 0, conf_sel 0, FSM IDLE, 2-stage response pipeline cleared; in-flight packet lost, no partial write completed.
REQ-029 After release, the first head beat is decoded normally; body beats before it are discarded.

Structure
REQ-030 Shared package holds tag encodings, ethertype codes, field bit positions and FSM state enumeration.
REQ-031 One sub-module natural: pkt_resp_pipe (2-stage response delay line with field substitution).

Verification
REQ-032 Head etype 9001 + body 128'h1_0000 + pad + tail -> conf_sel = 1 two cycles after body beat, no outputs.
REQ-033 conf_sel = 1, etype 9003 with body {instr 32'h1000_0537, addr 0} -> prog_wren at addr 0, wdata 32'h1000_0537; repeat with conf_sel = 0 -> no prog_wren.
REQ-034 etype 9004, body addr 1, memory[1] = 32'h0440_0593 -> resp_out body [79:48] = 32'h0440_0593, 2 cycles after request, DA/SA swapped on head.
REQ-035 ARP packet (etype 0806, 4 beats) -> identical 4 beats on bypass_out with 1-cycle latency, resp_out idle.
REQ-036 Head 9003 then new head 0806 before tail -> no write from the aborted packet; ARP bypassed intact.
REQ-037 rst_n pulse mid-WR_PROG -> outputs 0, conf_sel 0; next 9002 request returns bit16 = 0.
